// File: rtl/rr_arbiter_8.sv
// ---------------------------------------------------------------------------
// rr_arbiter_8
//   Round-robin arbiter sharing one resource among 8 requesters. A rotating
//   priority pointer picks the next winner. The winner keeps the grant until
//   one of three things happens: it drops its request, en drops, or it has
//   held the grant for MAX_HOLD cycles. All outputs are registered.
//
// Ports
//   clk        in   1    rising-edge clock
//   rst        in   1    synchronous, active-high reset
//   en         in   1    enable; 0 blocks new grants and releases the current one
//   req        in   N    level-sensitive request vector, bit i = requester i
//   gnt        out  N    one-hot grant, zero when there is no owner
//   gnt_id     out  IDW  encoded owner index, zero when gnt_valid is 0
//   gnt_valid  out  1    high while a grant is held
//   timeout    out  1    one-cycle pulse when the grant is revoked only by MAX_HOLD
// ---------------------------------------------------------------------------
module rr_arbiter_8 #(
  parameter int N        = 8,
  parameter int IDW      = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid,
  output logic           timeout
);

  // hold_cnt counts 0 .. MAX_HOLD-1 and is cleared on release, so it never wraps
  localparam int HCW = $clog2(MAX_HOLD) + 1;
  localparam bit HOLD_LIMITED = (MAX_HOLD != 0);
  localparam logic [HCW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HCW'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t         state, state_n;
  logic [IDW-1:0] ptr, ptr_n;
  logic [HCW-1:0] hold_cnt, hold_n;
  logic [N-1:0]   gnt_n;
  logic [IDW-1:0] gnt_id_n;
  logic           gnt_valid_n;
  logic           timeout_n;

  logic           found;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] cand;
  logic           rel_req;
  logic           rel_en;
  logic           rel_hold;

  // Rotating search: scan ptr, ptr+1, ... with natural IDW-bit wrap; the
  // first set request wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 0; i < N; i++) begin
      cand = ptr + IDW'(i);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Next-state and next-output logic. The owner's identity lives in gnt_id,
  // so the release conditions index req with it directly.
  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    hold_n      = hold_cnt;
    gnt_n       = gnt;
    gnt_id_n    = gnt_id;
    gnt_valid_n = gnt_valid;
    timeout_n   = 1'b0;
    rel_req     = 1'b0;
    rel_en      = 1'b0;
    rel_hold    = 1'b0;

    case (state)
      IDLE: begin
        gnt_n       = '0;
        gnt_id_n    = '0;
        gnt_valid_n = 1'b0;
        if (en && found) begin
          gnt_n         = '0;
          gnt_n[winner] = 1'b1;
          gnt_id_n      = winner;
          gnt_valid_n   = 1'b1;
          hold_n        = '0;
          state_n       = GRANT;
        end
      end

      GRANT: begin
        rel_req  = !req[gnt_id];
        rel_en   = !en;
        rel_hold = HOLD_LIMITED && (hold_cnt == HOLD_LAST);
        if (rel_req || rel_en || rel_hold) begin
          // Releasing always costs one IDLE cycle before the next grant
          gnt_n       = '0;
          gnt_id_n    = '0;
          gnt_valid_n = 1'b0;
          hold_n      = '0;
          ptr_n       = gnt_id + IDW'(1);
          timeout_n   = rel_hold && !rel_req && !rel_en;
          state_n     = IDLE;
        end else begin
          hold_n = hold_cnt + HCW'(1);
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers; reset overrides everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      hold_cnt  <= hold_n;
      gnt       <= gnt_n;
      gnt_id    <= gnt_id_n;
      gnt_valid <= gnt_valid_n;
      timeout   <= timeout_n;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter_8
//   Self-checking bench for rr_arbiter_8 (built with MAX_HOLD = 4). A
//   behavioural model tracks the owner as an integer and the hold time as a
//   count of granted cycles; every scenario compares the DUT against it and,
//   where the expected result is known up front, against fixed values too.
// ---------------------------------------------------------------------------
module tb_rr_arbiter_8;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  // Reference model state: owner = -1 means nobody holds the grant,
  // held = number of cycles the current grant has been visible.
  int m_owner;
  int m_ptr;
  int m_held;
  bit m_timeout;

  rr_arbiter_8 #(.N(8), .IDW(3), .MAX_HOLD(MAXH)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] obs_vec();
    return {gnt, gnt_id, gnt_valid, timeout};
  endfunction

  function automatic logic [12:0] exp_vec();
    logic [7:0] g;
    logic [2:0] id;
    g  = 8'h00;
    id = 3'd0;
    if (m_owner >= 0) begin
      g  = 8'(1) << m_owner;
      id = 3'(m_owner);
    end
    return {g, id, (m_owner >= 0), m_timeout};
  endfunction

  // Advance one clock: the model consumes the inputs as sampled at the
  // rising edge, then we move to the falling edge where outputs are compared.
  task automatic step();
    bit by_req, by_en, by_hold, found;
    int k;
    @(posedge clk);
    m_timeout = 1'b0;
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
    end else if (m_owner < 0) begin
      found = 1'b0;
      if (en && req != 8'h00) begin
        for (int j = 0; j < 8; j++) begin
          k = (m_ptr + j) % 8;
          if (!found && req[k]) begin
            found   = 1'b1;
            m_owner = k;
            m_held  = 1;
          end
        end
      end
    end else begin
      by_req  = !req[m_owner];
      by_en   = !en;
      by_hold = (MAXH != 0) && (m_held == MAXH);
      if (by_req || by_en || by_hold) begin
        m_timeout = by_hold && !by_req && !by_en;
        m_ptr     = (m_owner + 1) % 8;
        m_owner   = -1;
        m_held    = 0;
      end else begin
        m_held = m_held + 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    req = 8'hFF;
    step();
    step();
    checks++;
    if (obs_vec() !== 13'h0000) begin
      errors++;
      $display("[TB] FAIL reset: got %h, expected 0000", obs_vec());
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    req = 8'b0000_1000;
    step();
    checks++;
    if (gnt !== 8'b0000_1000 || gnt_id !== 3'd3 || gnt_valid !== 1'b1 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL single_grant: got gnt=%b id=%0d v=%b, expected gnt=00001000 id=3 v=1",
               gnt, gnt_id, gnt_valid);
    end
    req = 8'h00;
    step();
    checks++;
    if (gnt_valid !== 1'b0 || gnt !== 8'h00 || timeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_release: got gnt=%b v=%b to=%b, expected all 0", gnt, gnt_valid, timeout);
    end
    // Search must now start at index 4, so 4 beats 2
    req = 8'b0001_0100;
    step();
    checks++;
    if (gnt_id !== 3'd4 || gnt_valid !== 1'b1 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL next_search: got id=%0d v=%b, expected id=4 v=1", gnt_id, gnt_valid);
    end
    req = 8'h00;
    step();
  endtask

  task automatic test_max_hold();
    int ids[4] = '{2, 3, 4, 2};
    logic [4:0] exp_c;
    req = 8'b0001_1100;
    for (int s = 1; s <= 16; s++) begin
      step();
      if ((s - 1) % 5 < 4)
        exp_c = {3'(ids[(s - 1) / 5]), 1'b1, 1'b0};
      else
        exp_c = {3'd0, 1'b0, 1'b1};
      checks++;
      if ({gnt_id, gnt_valid, timeout} !== exp_c || obs_vec() !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL max_hold step %0d: got id/v/to=%b gnt=%b, expected %b model %h",
                 s, {gnt_id, gnt_valid, timeout}, gnt, exp_c, exp_vec());
      end
    end
    req = 8'h00;
    step();
  endtask

  task automatic test_en_drop();
    req = 8'b0010_0000;
    step();
    checks++;
    if (gnt_id !== 3'd5 || gnt_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL en_drop_grant: got id=%0d v=%b, expected id=5 v=1", gnt_id, gnt_valid);
    end
    step();
    en = 1'b0;
    step();
    checks++;
    if (gnt_valid !== 1'b0 || timeout !== 1'b0 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL en_drop_release: got v=%b to=%b, expected v=0 to=0", gnt_valid, timeout);
    end
    req = 8'b1110_0000;
    for (int s = 0; s < 3; s++) begin
      step();
      checks++;
      if (gnt_valid !== 1'b0 || gnt !== 8'h00) begin
        errors++;
        $display("[TB] FAIL en_low_idle %0d: got gnt=%b v=%b, expected 0", s, gnt, gnt_valid);
      end
    end
    en = 1'b1;
    step();
    checks++;
    if (gnt_id !== 3'd6 || gnt_valid !== 1'b1 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL en_resume: got id=%0d v=%b, expected id=6 v=1", gnt_id, gnt_valid);
    end
  endtask

  task automatic test_wrap();
    req = 8'b1000_0001;
    step();
    step();
    checks++;
    if (gnt_id !== 3'd7 || gnt !== 8'b1000_0000 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL wrap_7: got id=%0d gnt=%b, expected id=7 gnt=10000000", gnt_id, gnt);
    end
    req = 8'b0000_0001;
    step();
    step();
    checks++;
    if (gnt_id !== 3'd0 || gnt !== 8'b0000_0001 || gnt_valid !== 1'b1 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL wrap_0: got id=%0d gnt=%b v=%b, expected id=0 gnt=00000001 v=1",
               gnt_id, gnt, gnt_valid);
    end
    req = 8'h00;
    step();
  endtask

  task automatic test_reset_mid();
    req = 8'b0001_0000;
    step();
    rst = 1'b1;
    step();
    checks++;
    if (obs_vec() !== 13'h0000) begin
      errors++;
      $display("[TB] FAIL reset_mid: got %h, expected 0000", obs_vec());
    end
    rst = 1'b0;
    req = 8'b0011_0000;
    step();
    checks++;
    if (gnt_id !== 3'd4 || gnt_valid !== 1'b1 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL reset_ptr: got id=%0d v=%b, expected id=4 v=1", gnt_id, gnt_valid);
    end
  endtask

  // Owner 4 is on its last allowed cycle and drops its request at the same
  // edge: release is attributed to the request, so no timeout pulse.
  task automatic test_timeout_tie();
    step();
    step();
    step();
    req = 8'b0010_0000;
    step();
    checks++;
    if (gnt_valid !== 1'b0 || timeout !== 1'b0 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL timeout_tie: got v=%b to=%b, expected v=0 to=0", gnt_valid, timeout);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      en  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0)
        req = 8'($urandom);
      step();
      checks++;
      if (obs_vec() !== exp_vec() ||
          gnt !== (gnt_valid ? (8'(1) << gnt_id) : 8'h00)) begin
        errors++;
        $display("[TB] FAIL random cycle %0d: got %h, expected %h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    m_owner   = -1;
    m_ptr     = 0;
    m_held    = 0;
    m_timeout = 1'b0;
    rst       = 1'b1;
    en        = 1'b1;
    req       = 8'h00;
    test_reset();
    test_single();
    test_max_hold();
    test_en_drop();
    test_wrap();
    test_reset_mid();
    test_timeout_tie();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
